// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// the control FSM state type and small opcode-decoding helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic is_div_op(op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if
// Request/result bundle of the multiply/divide unit.
//   start, op, a, b      : operation request (master -> slave)
//   hi_wr, lo_wr, wdata  : direct Hi/Lo writes (master -> slave)
//   busy, done, divby0   : status (slave -> master)
//   hi, lo               : registered Hi/Lo contents (slave -> master)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             divby0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wdata,
        input  busy, done, divby0, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wdata,
        output busy, done, divby0, hi, lo
    );

endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix
// Combinational sign handling around the unsigned iterative core.
//   a_i, b_i, sgn_i        : raw operands and "treat as signed" flag
//   a_mag_o, b_mag_o       : operand magnitudes
//   neg_q_o, neg_r_o       : result signs (product/quotient, remainder)
//   is_div_i               : stored operation class for the correction
//   fix_neg_q_i, fix_neg_r_i : stored result signs
//   raw_i                  : unsigned result {remainder,quotient} or product
//   hi_o, lo_o             : sign-corrected Hi/Lo values
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               sgn_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    output logic               neg_q_o,
    output logic               neg_r_o,
    input  logic               is_div_i,
    input  logic               fix_neg_q_i,
    input  logic               fix_neg_r_i,
    input  logic [2*WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);
    logic             a_neg;
    logic             b_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign a_neg   = sgn_i & a_i[WIDTH-1];
    assign b_neg   = sgn_i & b_i[WIDTH-1];
    // Negating MIN wraps back to MIN, which read as unsigned is exactly |MIN|.
    assign a_mag_o = a_neg ? -a_i : a_i;
    assign b_mag_o = b_neg ? -b_i : b_i;
    assign neg_q_o = a_neg ^ b_neg;
    // Truncating division: remainder follows the dividend's sign.
    assign neg_r_o = a_neg;

    assign prod_fix = fix_neg_q_i ? -raw_i : raw_i;
    assign quo_fix  = fix_neg_q_i ? -raw_i[WIDTH-1:0] : raw_i[WIDTH-1:0];
    assign rem_fix  = fix_neg_r_i ? -raw_i[2*WIDTH-1:WIDTH] : raw_i[2*WIDTH-1:WIDTH];

    assign hi_o = is_div_i ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_o = is_div_i ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative MIPS-style multiply/divide unit with Hi/Lo registers.
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// WIDTH steps per operation, followed by one sign-correction cycle.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : muldiv_if slave (request, direct Hi/Lo writes, status, Hi/Lo)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic     Clk,
    input  logic     Reset,
    muldiv_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic               div_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               divby0_q;
    logic               dz_pend_q;

    logic               accept;
    logic               in_sgn;
    logic               in_div;
    logic               dz;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               in_neg_q;
    logic               in_neg_r;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [2*WIDTH-1:0] acc_step;

    assign accept = (state_q == ST_IDLE) && bus.start;
    assign in_sgn = (SIGNED_EN != 0) && is_signed_op(bus.op);
    assign in_div = is_div_op(bus.op);
    assign dz     = accept && in_div && (bus.b == '0);

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .a_i         (bus.a),
        .b_i         (bus.b),
        .sgn_i       (in_sgn),
        .a_mag_o     (a_mag),
        .b_mag_o     (b_mag),
        .neg_q_o     (in_neg_q),
        .neg_r_o     (in_neg_r),
        .is_div_i    (div_q),
        .fix_neg_q_i (neg_q_q),
        .fix_neg_r_i (neg_r_q),
        .raw_i       (acc_q),
        .hi_o        (fix_hi),
        .lo_o        (fix_lo)
    );

    // Shared WIDTH+1-bit adder/subtractor. For divide it computes
    // (shifted remainder - divisor); the extra top bit is the no-borrow flag.
    always_comb begin
        if (div_q) begin
            add_a   = acc_q[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_b   = {1'b0, opnd_q};
            add_cin = 1'b0;
        end
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        if (div_q) begin
            if (add_sum[WIDTH+1])
                acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0])
                acc_step = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // FSM: state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next-state logic; a zero divisor never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !dz)   state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST)   state_d = ST_FIX;
            ST_FIX:                       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (state_q != ST_IDLE);
    end

    // Datapath and Hi/Lo registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divby0_q  <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            done_q    <= dz_pend_q;
            divby0_q  <= dz_pend_q;
            dz_pend_q <= dz;

            case (state_q)
                ST_IDLE: begin
                    if (accept && !dz) begin
                        acc_q   <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                        opnd_q  <= in_div ? b_mag : a_mag;
                        div_q   <= in_div;
                        neg_q_q <= in_neg_q;
                        neg_r_q <= in_neg_r;
                        cnt_q   <= '0;
                    end
                    if (bus.hi_wr) hi_q <= bus.wdata;
                    if (bus.lo_wr) lo_q <= bus.wdata;
                end
                ST_RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                ST_FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.divby0 = divby0_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed tests of muldiv_unit (WIDTH=32) with hand-computed results.
// u_dut0 is the signed-capable unit; u_dut1 has SIGNED_EN=0.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic Clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;

    muldiv_if #(.WIDTH(32)) bus0 ();
    muldiv_if #(.WIDTH(32)) bus1 ();

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(1)) u_dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0)
    );

    muldiv_unit #(.WIDTH(32), .SIGNED_EN(0)) u_dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // advance one rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // present a request to u_dut0 for exactly one edge (the accept edge)
    task automatic issue0(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus0.start = 1'b1;
        bus0.op    = op;
        bus0.a     = a;
        bus0.b     = b;
        step();
        bus0.start = 1'b0;
    endtask

    // edges after the accept edge until done is seen (bounded at 100)
    task automatic wait_done0(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus0.done !== 1'b1 && n < 100);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        tests_run++; if (bus0.busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        tests_run++; if (bus0.done !== 1'b0)   begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus0.done); end
        tests_run++; if (bus0.divby0 !== 1'b0) begin tests_failed++; $display("FAIL reset_divby0: got %b want 0", bus0.divby0); end
        tests_run++; if (bus0.hi !== 32'h0)    begin tests_failed++; $display("FAIL reset_hi: got %h want 0", bus0.hi); end
        tests_run++; if (bus0.lo !== 32'h0)    begin tests_failed++; $display("FAIL reset_lo: got %h want 0", bus0.lo); end
        Reset = 1'b0;
        step();
        $display("[TB] reset checked");
    endtask

    task automatic test_mult_timing();
        int  k;
        bit  busy_ok;
        issue0(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        busy_ok = (bus0.busy === 1'b1);
        k = 0;
        do begin
            step();
            k++;
            if (bus0.done !== 1'b1 && bus0.busy !== 1'b1) busy_ok = 1'b0;
        end while (bus0.done !== 1'b1 && k < 100);
        tests_run++; if (k != 33)               begin tests_failed++; $display("FAIL mult_done_edge: got %0d want 33", k); end
        tests_run++; if (!busy_ok)              begin tests_failed++; $display("FAIL mult_busy_run: got busy low want high before done"); end
        tests_run++; if (bus0.busy !== 1'b0)    begin tests_failed++; $display("FAIL mult_busy_done: got %b want 0", bus0.busy); end
        tests_run++; if (bus0.hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi: got %h want ffffffff", bus0.hi); end
        tests_run++; if (bus0.lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_lo: got %h want ffffffeb", bus0.lo); end
        step();
        tests_run++; if (bus0.done !== 1'b0)    begin tests_failed++; $display("FAIL mult_done_pulse: got %b want 0", bus0.done); end
        $display("[TB] MULT fffffffd*7 -> hi=%h lo=%h done_edge=%0d", bus0.hi, bus0.lo, k);
    endtask

    task automatic test_back_to_back();
        int n;
        issue0(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done0(n);
        tests_run++; if (n != 33)                   begin tests_failed++; $display("FAIL multu_done_edge: got %0d want 33", n); end
        tests_run++; if (bus0.hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi: got %h want fffffffe", bus0.hi); end
        tests_run++; if (bus0.lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo: got %h want 00000001", bus0.lo); end
        $display("[TB] MULTU ffffffff*ffffffff -> hi=%h lo=%h", bus0.hi, bus0.lo);
        // start issued in the done cycle
        issue0(OP_DIVU, 32'd100, 32'd7);
        tests_run++; if (bus0.busy !== 1'b1)        begin tests_failed++; $display("FAIL b2b_accept: got busy %b want 1", bus0.busy); end
        wait_done0(n);
        tests_run++; if (n != 33)                   begin tests_failed++; $display("FAIL divu_done_edge: got %0d want 33", n); end
        tests_run++; if (bus0.lo !== 32'd14)        begin tests_failed++; $display("FAIL divu_lo: got %h want 0000000e", bus0.lo); end
        tests_run++; if (bus0.hi !== 32'd2)         begin tests_failed++; $display("FAIL divu_hi: got %h want 00000002", bus0.hi); end
        $display("[TB] DIVU 100/7 back-to-back -> lo=%0d hi=%0d", bus0.lo, bus0.hi);
    endtask

    task automatic test_write_with_start();
        int n;
        bus0.lo_wr = 1'b1;
        bus0.wdata = 32'h0000_0055;
        issue0(OP_MULTU, 32'd3, 32'd4);
        bus0.lo_wr = 1'b0;
        tests_run++; if (bus0.lo !== 32'h55)   begin tests_failed++; $display("FAIL wr_start_lo: got %h want 00000055", bus0.lo); end
        tests_run++; if (bus0.busy !== 1'b1)   begin tests_failed++; $display("FAIL wr_start_busy: got %b want 1", bus0.busy); end
        wait_done0(n);
        tests_run++; if (bus0.lo !== 32'd12)   begin tests_failed++; $display("FAIL wr_start_res_lo: got %h want 0000000c", bus0.lo); end
        tests_run++; if (bus0.hi !== 32'd0)    begin tests_failed++; $display("FAIL wr_start_res_hi: got %h want 00000000", bus0.hi); end
        $display("[TB] MTLO+MULTU 3*4 -> hi=%h lo=%h", bus0.hi, bus0.lo);
    endtask

    task automatic test_div_signed();
        int n;
        issue0(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done0(n);
        tests_run++; if (bus0.lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_neg_lo: got %h want fffffffd", bus0.lo); end
        tests_run++; if (bus0.hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_neg_hi: got %h want ffffffff", bus0.hi); end
        $display("[TB] DIV -7/2 -> lo=%h hi=%h", bus0.lo, bus0.hi);
        issue0(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done0(n);
        tests_run++; if (bus0.lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_min_lo: got %h want 80000000", bus0.lo); end
        tests_run++; if (bus0.hi !== 32'h0)         begin tests_failed++; $display("FAIL div_min_hi: got %h want 00000000", bus0.hi); end
        tests_run++; if (bus0.divby0 !== 1'b0)      begin tests_failed++; $display("FAIL div_min_flag: got %b want 0", bus0.divby0); end
        $display("[TB] DIV MIN/-1 -> lo=%h hi=%h", bus0.lo, bus0.hi);
    endtask

    task automatic test_divby0();
        bit busy_seen;
        bus0.lo_wr = 1'b1;
        bus0.wdata = 32'h0000_ABCD;
        step();
        bus0.lo_wr = 1'b0;
        bus0.hi_wr = 1'b1;
        bus0.wdata = 32'h0000_1234;
        step();
        bus0.hi_wr = 1'b0;
        tests_run++; if (bus0.hi !== 32'h1234) begin tests_failed++; $display("FAIL mthi: got %h want 00001234", bus0.hi); end
        issue0(OP_DIV, 32'd5, 32'd0);
        busy_seen = (bus0.busy !== 1'b0);
        tests_run++; if (bus0.done !== 1'b0)   begin tests_failed++; $display("FAIL dz_done_early: got %b want 0", bus0.done); end
        step();
        busy_seen = busy_seen || (bus0.busy !== 1'b0);
        tests_run++; if (bus0.done !== 1'b1)   begin tests_failed++; $display("FAIL dz_done: got %b want 1", bus0.done); end
        tests_run++; if (bus0.divby0 !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b want 1", bus0.divby0); end
        step();
        busy_seen = busy_seen || (bus0.busy !== 1'b0);
        tests_run++; if (bus0.done !== 1'b0 || bus0.divby0 !== 1'b0) begin tests_failed++; $display("FAIL dz_pulse: got done=%b divby0=%b want 0 0", bus0.done, bus0.divby0); end
        tests_run++; if (busy_seen)            begin tests_failed++; $display("FAIL dz_busy: got busy high want never"); end
        tests_run++; if (bus0.hi !== 32'h1234) begin tests_failed++; $display("FAIL dz_hi: got %h want 00001234", bus0.hi); end
        tests_run++; if (bus0.lo !== 32'hABCD) begin tests_failed++; $display("FAIL dz_lo: got %h want 0000abcd", bus0.lo); end
        $display("[TB] DIV 5/0 -> divby0 pulse, hi=%h lo=%h", bus0.hi, bus0.lo);
    endtask

    task automatic test_ignore_and_reset();
        bit done_seen;
        bit busy_seen;
        issue0(OP_MULT, 32'd3, 32'd5);           // accept = edge 0
        for (int i = 1; i <= 4; i++) step();     // edges 1..4
        bus0.start = 1'b1;
        bus0.op    = OP_DIVU;
        bus0.a     = 32'd9;
        bus0.b     = 32'd3;
        bus0.hi_wr = 1'b1;
        bus0.wdata = 32'h0000_FFFF;
        step();                                  // edge 5
        bus0.start = 1'b0;
        bus0.hi_wr = 1'b0;
        tests_run++; if (bus0.busy !== 1'b1)   begin tests_failed++; $display("FAIL ign_busy: got %b want 1", bus0.busy); end
        tests_run++; if (bus0.hi !== 32'h1234) begin tests_failed++; $display("FAIL ign_hi_wr: got %h want 00001234", bus0.hi); end
        for (int i = 6; i <= 9; i++) step();     // edges 6..9
        @(posedge Clk);                          // edge 10
        Reset = 1'b1;
        #1;
        tests_run++; if (bus0.busy !== 1'b0)   begin tests_failed++; $display("FAIL rst_mid_busy: got %b want 0", bus0.busy); end
        tests_run++; if (bus0.hi !== 32'h0 || bus0.lo !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", bus0.hi, bus0.lo); end
        step();
        Reset = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus0.done !== 1'b0) done_seen = 1'b1;
            if (bus0.busy !== 1'b0) busy_seen = 1'b1;
        end
        tests_run++; if (done_seen) begin tests_failed++; $display("FAIL rst_no_done: got done pulse want none"); end
        tests_run++; if (busy_seen) begin tests_failed++; $display("FAIL rst_no_busy: got busy want idle"); end
        tests_run++; if (bus0.hi !== 32'h0 || bus0.lo !== 32'h0) begin tests_failed++; $display("FAIL rst_no_result: got %h/%h want 0/0", bus0.hi, bus0.lo); end
        $display("[TB] mid-op start/hi_wr ignored, reset abandons op");
    endtask

    task automatic test_unsigned_en();
        int n;
        bus0.start = 1'b1; bus0.op = OP_MULT; bus0.a = 32'hFFFF_FFFF; bus0.b = 32'd2;
        bus1.start = 1'b1; bus1.op = OP_MULT; bus1.a = 32'hFFFF_FFFF; bus1.b = 32'd2;
        step();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        wait_done0(n);
        tests_run++; if (bus1.done !== 1'b1)         begin tests_failed++; $display("FAIL uns_done: got %b want 1", bus1.done); end
        tests_run++; if (bus1.hi !== 32'h0000_0001)  begin tests_failed++; $display("FAIL uns_hi: got %h want 00000001", bus1.hi); end
        tests_run++; if (bus1.lo !== 32'hFFFF_FFFE)  begin tests_failed++; $display("FAIL uns_lo: got %h want fffffffe", bus1.lo); end
        tests_run++; if (bus0.hi !== 32'hFFFF_FFFF)  begin tests_failed++; $display("FAIL sgn_hi: got %h want ffffffff", bus0.hi); end
        tests_run++; if (bus0.lo !== 32'hFFFF_FFFE)  begin tests_failed++; $display("FAIL sgn_lo: got %h want fffffffe", bus0.lo); end
        $display("[TB] MULT ffffffff*2 SIGNED_EN=0 -> hi=%h lo=%h; SIGNED_EN=1 -> hi=%h lo=%h",
                 bus1.hi, bus1.lo, bus0.hi, bus0.lo);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset = 1'b1;
        bus0.start = 1'b0; bus0.op = OP_MULT; bus0.a = '0; bus0.b = '0;
        bus0.hi_wr = 1'b0; bus0.lo_wr = 1'b0; bus0.wdata = '0;
        bus1.start = 1'b0; bus1.op = OP_MULT; bus1.a = '0; bus1.b = '0;
        bus1.hi_wr = 1'b0; bus1.lo_wr = 1'b0; bus1.wdata = '0;

        test_reset();
        test_mult_timing();
        test_back_to_back();
        test_write_with_start();
        test_div_signed();
        test_divby0();
        test_ignore_and_reset();
        test_unsigned_en();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and Hi/Lo width (legal range 8..64).
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 0, signed opcodes execute as unsigned.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: operation request.
REQ-006 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have ports a and b, inputs, WIDTH bits each: multiplicand/dividend and multiplier/divisor.
REQ-008 SHALL have ports hi_wr and lo_wr, inputs, 1 bit each: direct writes for MTHI and MTLO.
REQ-009 SHALL have port wdata, input, WIDTH bits: data for hi_wr and lo_wr.
REQ-010 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port divby0, output, 1 bit: one-cycle pulse coincident with done on a zero divisor.
REQ-013 SHALL have ports hi and lo, outputs, WIDTH bits each: registered Hi and Lo contents.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and FIX, with busy=1 exactly in RUN and FIX.
REQ-015 SHALL accept start only in IDLE, capture a, b and op on the accepting edge, and ignore start while busy.
REQ-016 SHALL, for a non-degenerate operation, go IDLE->RUN on the accept edge, perform one shift-add or restoring-subtract step per edge for WIDTH edges, and then go RUN->FIX.
REQ-017 SHALL, on the FIX edge, apply the sign correction, write hi/lo, set done=1 and return to IDLE; done rises on edge WIDTH+1 after the accept edge (33 for WIDTH=32).
REQ-018 SHALL, for MULT/MULTU, produce the 2*WIDTH-bit product as {hi,lo}; signed results are two's complement.
REQ-019 SHALL, for DIV/DIVU, set lo=quotient and hi=remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 SHALL, for signed MIN/-1, produce lo=MIN and hi=0 with no flag.
REQ-021 SHALL, for DIV/DIVU with b==0, stay in IDLE, pulse done and divby0 on the edge after accept, and leave hi/lo unchanged.
REQ-022 SHALL hold done and divby0 high for exactly one cycle; a new start in that done cycle is accepted (back-to-back).
REQ-023 SHALL honour hi_wr and lo_wr only when busy=0; when either coincides with an accepted start, the write takes effect and the operation still proceeds and later overwrites.
REQ-024 SHALL change hi/lo only on the FIX edge, on a hi_wr/lo_wr write, or on reset.

Reset
REQ-025 SHALL, on Reset=1 at any time including mid-operation, immediately force state=IDLE, busy=0, done=0, divby0=0, hi=0, lo=0 and clear the iteration counter and internal operands.
REQ-026 SHALL NOT complete, pulse done or deliver a partial result for an operation abandoned by reset.

Structure
REQ-027 SHALL take the op encodings and the FSM state type from shared package muldiv_pkg.
REQ-028 SHALL use one sub-module, muldiv_signfix, for operand magnitude extraction and result sign correction; it is combinational, WIDTH-parametrised and instantiated once.
REQ-029 SHALL share one 2*WIDTH-bit shift register and one WIDTH+1-bit adder/subtractor between multiply and divide.
REQ-030 SHALL size the iteration counter as $clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-031 MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done on edge 33, busy high edges 1..32.
REQ-032 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 started in the done cycle -> accepted, lo=14, hi=2.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 hi_wr with wdata=0x1234, then DIV 5/0 -> done=divby0=1 on edge after accept, busy never 1, hi=0x1234, lo unchanged.
REQ-035 Start MULT, pulse start again and hi_wr on edge 5 -> both ignored; Reset on edge 10 -> busy=0, hi=lo=0, no done afterward.
REQ-036 SIGNED_EN=0, MULT 0xFFFFFFFF*2 -> hi=0x00000001, lo=0xFFFFFFFE.
